// File: rtl/edge_walker.sv
// edge_walker: raster-order triangle scan converter with incremental edge functions.
// Optional RASTER_BBOX_EN restricts the walk to the screen-clamped vertex bounding box.
module edge_walker #(
    parameter int H_RES   = 640,
    parameter int V_RES   = 480,
    parameter int COORD_W = 10
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [COORD_W-1:0] x0,
    input  logic [COORD_W-1:0] y0,
    input  logic [COORD_W-1:0] x1,
    input  logic [COORD_W-1:0] y1,
    input  logic [COORD_W-1:0] x2,
    input  logic [COORD_W-1:0] y2,
    output logic               busy,
    output logic               done,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [COORD_W-1:0] out_x,
    output logic [COORD_W-1:0] out_y,
    output logic               out_last,
    output logic               visible,
    output logic [17:0]        ua,
    output logic [17:0]        va,
    output logic [17:0]        wa,
    output logic [18:0]        a
);

    // state | meaning
    // IDLE  | waiting for start, vertices latched on start
    // SETUP | area, steps and first-pixel edge values computed
    // WALK  | presenting beats, advancing on each accepted beat
    typedef enum logic [1:0] {IDLE, SETUP, WALK} state_t;

    localparam int EW = 22;
    localparam logic [COORD_W-1:0] X_END = COORD_W'(H_RES - 1);
    localparam logic [COORD_W-1:0] Y_END = COORD_W'(V_RES - 1);

    state_t state, state_nx;

    logic [COORD_W-1:0]   vx0, vy0, vx1, vy1, vx2, vy2;
    logic [COORD_W-1:0]   px, py;
    logic [COORD_W-1:0]   first_x, first_y, last_x, last_y;
    logic signed [EW-1:0] e_a;
    logic signed [EW-1:0] u, v, w, ru, rv, rw;
    logic signed [EW-1:0] sxu, sxv, sxw, syu, syv, syw;
    logic                 walk, accept, at_row_end, at_end, pos_area;

    function automatic logic signed [EW-1:0] dif(input logic [COORD_W-1:0] p,
                                                 input logic [COORD_W-1:0] q);
        return $signed(EW'(p)) - $signed(EW'(q));
    endfunction

    function automatic logic signed [EW-1:0] edge_fn(input logic [COORD_W-1:0] ax,
                                                     input logic [COORD_W-1:0] ay,
                                                     input logic [COORD_W-1:0] bx,
                                                     input logic [COORD_W-1:0] by,
                                                     input logic [COORD_W-1:0] qx,
                                                     input logic [COORD_W-1:0] qy);
        return dif(bx, ax) * dif(qy, ay) - dif(by, ay) * dif(qx, ax);
    endfunction

    // Edge values are non-negative whenever this is used, so only overflow matters.
    function automatic logic [17:0] sat18(input logic signed [EW-1:0] e);
        if (|e[EW-1:18]) return '1;
        return e[17:0];
    endfunction

`ifdef RASTER_BBOX_EN
    function automatic logic [COORD_W-1:0] min3(input logic [COORD_W-1:0] p,
                                                input logic [COORD_W-1:0] q,
                                                input logic [COORD_W-1:0] r);
        logic [COORD_W-1:0] m;
        m = (p < q) ? p : q;
        return (r < m) ? r : m;
    endfunction

    function automatic logic [COORD_W-1:0] max3(input logic [COORD_W-1:0] p,
                                                input logic [COORD_W-1:0] q,
                                                input logic [COORD_W-1:0] r);
        logic [COORD_W-1:0] m;
        m = (p > q) ? p : q;
        return (r > m) ? r : m;
    endfunction

    function automatic logic [COORD_W-1:0] clamp(input logic [COORD_W-1:0] p,
                                                 input logic [COORD_W-1:0] lim);
        return (p > lim) ? lim : p;
    endfunction

    // Vertex registers hold for the whole walk, so the box needs no storage.
    assign first_x = clamp(min3(vx0, vx1, vx2), X_END);
    assign first_y = clamp(min3(vy0, vy1, vy2), Y_END);
    assign last_x  = clamp(max3(vx0, vx1, vx2), X_END);
    assign last_y  = clamp(max3(vy0, vy1, vy2), Y_END);
`else
    assign first_x = '0;
    assign first_y = '0;
    assign last_x  = X_END;
    assign last_y  = Y_END;
`endif

    assign walk       = (state == WALK);
    assign accept     = walk & out_ready;
    assign at_row_end = (px == last_x);
    assign at_end     = at_row_end & (py == last_y);

    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (start) state_nx = SETUP;
            SETUP:   state_nx = WALK;
            WALK:    if (accept && at_end) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            done <= 1'b0;
            vx0  <= '0; vy0 <= '0; vx1 <= '0; vy1 <= '0; vx2 <= '0; vy2 <= '0;
            px   <= '0; py  <= '0;
            e_a  <= '0;
            u    <= '0; v   <= '0; w   <= '0;
            ru   <= '0; rv  <= '0; rw  <= '0;
            sxu  <= '0; sxv <= '0; sxw <= '0;
            syu  <= '0; syv <= '0; syw <= '0;
        end else begin
            done <= accept & at_end;
            case (state)
                IDLE: begin
                    if (start) begin
                        vx0 <= x0; vy0 <= y0;
                        vx1 <= x1; vy1 <= y1;
                        vx2 <= x2; vy2 <= y2;
                    end
                end
                SETUP: begin
                    e_a <= edge_fn(vx0, vy0, vx1, vy1, vx2, vy2);
                    u   <= edge_fn(vx1, vy1, vx2, vy2, first_x, first_y);
                    v   <= edge_fn(vx2, vy2, vx0, vy0, first_x, first_y);
                    w   <= edge_fn(vx0, vy0, vx1, vy1, first_x, first_y);
                    ru  <= edge_fn(vx1, vy1, vx2, vy2, first_x, first_y);
                    rv  <= edge_fn(vx2, vy2, vx0, vy0, first_x, first_y);
                    rw  <= edge_fn(vx0, vy0, vx1, vy1, first_x, first_y);
                    sxu <= dif(vy1, vy2);
                    sxv <= dif(vy2, vy0);
                    sxw <= dif(vy0, vy1);
                    syu <= dif(vx2, vx1);
                    syv <= dif(vx0, vx2);
                    syw <= dif(vx1, vx0);
                    px  <= first_x;
                    py  <= first_y;
                end
                WALK: begin
                    if (accept && !at_end) begin
                        if (at_row_end) begin
                            px <= first_x;
                            py <= py + COORD_W'(1);
                            u  <= ru + syu;
                            v  <= rv + syv;
                            w  <= rw + syw;
                            ru <= ru + syu;
                            rv <= rv + syv;
                            rw <= rw + syw;
                        end else begin
                            px <= px + COORD_W'(1);
                            u  <= u + sxu;
                            v  <= v + sxv;
                            w  <= w + sxw;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign pos_area  = ~e_a[EW-1] & (|e_a);
    assign busy      = (state != IDLE);
    assign out_valid = walk;
    assign out_last  = walk & at_end;
    assign out_x     = walk ? px : '0;
    assign out_y     = walk ? py : '0;
    assign visible   = walk & pos_area & ~u[EW-1] & ~v[EW-1] & ~w[EW-1];
    assign ua        = visible ? sat18(u) : '0;
    assign va        = visible ? sat18(v) : '0;
    assign wa        = visible ? sat18(w) : '0;
    assign a         = visible ? e_a[18:0] : '0;

endmodule

// File: tb/tb_edge_walker.sv
// Bench for edge_walker on an 8x8 screen: directed cases plus random triangles
// with random backpressure, all checked against a per-pixel arithmetic model.
module tb_edge_walker;

    localparam int H  = 8;
    localparam int V  = 8;
    localparam int CW = 10;

    logic          clk = 1'b0;
    logic          rst_n, start, out_ready;
    logic [CW-1:0] x0, y0, x1, y1, x2, y2;
    logic          busy, done, out_valid, out_last, visible;
    logic [CW-1:0] out_x, out_y;
    logic [17:0]   ua, va, wa;
    logic [18:0]   a;

    edge_walker #(.H_RES(H), .V_RES(V), .COORD_W(CW)) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .x0(x0), .y0(y0), .x1(x1), .y1(y1), .x2(x2), .y2(y2),
        .busy(busy), .done(done), .out_valid(out_valid), .out_ready(out_ready),
        .out_x(out_x), .out_y(out_y), .out_last(out_last), .visible(visible),
        .ua(ua), .va(va), .wa(wa), .a(a)
    );

    always #5 clk = ~clk;

    typedef struct {
        int x; int y; bit last; bit vis; int ua; int va; int wa; int ar;
    } beat_t;

    beat_t q[$];
    int n_cmp = 0;
    int n_err = 0;
    bit m_idle = 1'b1, m_setup = 1'b0, pend_done = 1'b0, want_first = 1'b0;
    int beat_cnt = 0, vis_cnt = 0, last_cnt = 0, done_cnt = 0, hold20 = 0;
    int first_cx = -1, first_cy = -1;
    int cv_ua[0:7][0:7], cv_va[0:7][0:7], cv_wa[0:7][0:7], cv_a[0:7][0:7];
    int cv_vis[0:7][0:7], cv_last[0:7][0:7];

    task automatic chk(input string name, input longint act, input longint exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: actual %0d required %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int efn(int ax, int ay, int bx, int by, int qx, int qy);
        return (bx - ax) * (qy - ay) - (by - ay) * (qx - ax);
    endfunction

    function automatic int mn3(int p, int r, int s);
        int m = (p < r) ? p : r;
        return (s < m) ? s : m;
    endfunction

    function automatic int mx3(int p, int r, int s);
        int m = (p > r) ? p : r;
        return (s > m) ? s : m;
    endfunction

    // Expected beat list for one walk, straight from the edge-function definition.
    task automatic build(input int ax0, input int ay0, input int ax1, input int ay1,
                         input int ax2, input int ay2);
        int ar, xl, xh, yl, yh, eu, ev, ew;
        beat_t e;
        ar = efn(ax0, ay0, ax1, ay1, ax2, ay2);
`ifdef RASTER_BBOX_EN
        xl = mn3(ax0, ax1, ax2); if (xl > H - 1) xl = H - 1;
        xh = mx3(ax0, ax1, ax2); if (xh > H - 1) xh = H - 1;
        yl = mn3(ay0, ay1, ay2); if (yl > V - 1) yl = V - 1;
        yh = mx3(ay0, ay1, ay2); if (yh > V - 1) yh = V - 1;
`else
        xl = 0; xh = H - 1; yl = 0; yh = V - 1;
`endif
        for (int yy = yl; yy <= yh; yy++) begin
            for (int xx = xl; xx <= xh; xx++) begin
                eu = efn(ax1, ay1, ax2, ay2, xx, yy);
                ev = efn(ax2, ay2, ax0, ay0, xx, yy);
                ew = efn(ax0, ay0, ax1, ay1, xx, yy);
                e.x    = xx;
                e.y    = yy;
                e.last = (xx == xh) && (yy == yh);
                e.vis  = (ar > 0) && (eu >= 0) && (ev >= 0) && (ew >= 0);
                e.ua   = e.vis ? ((eu > 262143) ? 262143 : eu) : 0;
                e.va   = e.vis ? ((ev > 262143) ? 262143 : ev) : 0;
                e.wa   = e.vis ? ((ew > 262143) ? 262143 : ew) : 0;
                e.ar   = e.vis ? (ar & 32'h7FFFF) : 0;
                q.push_back(e);
            end
        end
    endtask

    // Per-cycle comparison against the model, then advance the model over the next edge.
    task automatic monitor();
        beat_t e;
        chk("busy", busy, !m_idle);
        chk("out_valid", out_valid, !m_idle && !m_setup);
        chk("done", done, pend_done);
        if (done) done_cnt++;
        if (out_valid) begin
            if (q.size() == 0) begin
                chk("spurious_beat", 1, 0);
            end else begin
                e = q[0];
                chk("out_x", out_x, e.x);
                chk("out_y", out_y, e.y);
                chk("out_last", out_last, e.last);
                chk("visible", visible, e.vis);
                chk("ua", ua, e.ua);
                chk("va", va, e.va);
                chk("wa", wa, e.wa);
                chk("a", a, e.ar);
            end
            if (want_first) begin
                first_cx = out_x; first_cy = out_y; want_first = 1'b0;
            end
            if (out_x < 8 && out_y < 8) begin
                cv_ua[out_x][out_y] = ua;  cv_va[out_x][out_y] = va;
                cv_wa[out_x][out_y] = wa;  cv_a[out_x][out_y]  = a;
                cv_vis[out_x][out_y] = visible; cv_last[out_x][out_y] = out_last;
            end
            if (out_x == 2 && out_y == 0) hold20++;
        end
        pend_done = 1'b0;
        m_setup   = 1'b0;
        if (!rst_n) begin
            q.delete();
            m_idle = 1'b1;
        end else if (start && m_idle) begin
            build(x0, y0, x1, y1, x2, y2);
            m_idle = 1'b0; m_setup = 1'b1; want_first = 1'b1;
        end else if (out_valid && out_ready && q.size() > 0) begin
            beat_cnt++;
            if (visible) vis_cnt++;
            if (out_last) last_cnt++;
            if (q[0].last) begin
                m_idle = 1'b1; pend_done = 1'b1;
            end
            void'(q.pop_front());
        end
    endtask

    task automatic step();
        @(negedge clk);
        monitor();
        @(posedge clk);
        #1;
    endtask

    task automatic launch(input int ax0, input int ay0, input int ax1, input int ay1,
                          input int ax2, input int ay2);
        x0 = CW'(ax0); y0 = CW'(ay0); x1 = CW'(ax1); y1 = CW'(ay1);
        x2 = CW'(ax2); y2 = CW'(ay2);
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    // mode 0: ready high, 1: random ready, 2: stall at (2,0), 3: start at (4,2) then reset at (5,3)
    task automatic run_walk(input int mode);
        int d0 = done_cnt;
        int stall = 0;
        bit fin = 1'b0;
        for (int c = 0; c < 600 && !fin; c++) begin
            start = 1'b0;
            case (mode)
                1: out_ready = ($urandom_range(0, 3) != 0);
                2: begin
                    if (out_valid && out_x == 2 && out_y == 0 && stall < 3) begin
                        out_ready = 1'b0; stall++;
                    end else out_ready = 1'b1;
                end
                3: begin
                    out_ready = 1'b1;
                    if (out_valid && out_x == 4 && out_y == 2) begin
                        start = 1'b1;
                        x0 = CW'($urandom_range(0, 7)); y0 = CW'($urandom_range(0, 7));
                    end
                    if (out_valid && out_x == 5 && out_y == 3) rst_n = 1'b0;
                end
                default: out_ready = 1'b1;
            endcase
            step();
            if (done_cnt != d0) fin = 1'b1;
            if (!rst_n) begin
                chk("abort_out_valid", out_valid, 0);
                chk("abort_busy", busy, 0);
                chk("abort_done", done, 0);
                rst_n = 1'b1;
                fin = 1'b1;
            end
        end
        if (!fin) chk("walk_timeout", 0, 1);
        start = 1'b0;
        out_ready = 1'b1;
    endtask

    int b0, v0c, l0, d0c, h0;

    task automatic snap();
        b0 = beat_cnt; v0c = vis_cnt; l0 = last_cnt; d0c = done_cnt; h0 = hold20;
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; out_ready = 1'b1;
        x0 = '0; y0 = '0; x1 = '0; y1 = '0; x2 = '0; y2 = '0;
        repeat (3) step();
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_valid", out_valid, 0);
        chk("rst_last", out_last, 0);
        chk("rst_visible", visible, 0);
        chk("rst_data", {ua, va, wa, a, out_x, out_y}, 0);
        rst_n = 1'b1;
        step();

        // right triangle, first-beat latency
        snap();
        launch(0, 0, 7, 0, 0, 7);
        chk("lat_busy_t1", busy, 1);
        chk("lat_valid_t1", out_valid, 0);
        step();
        chk("lat_valid_t2", out_valid, 1);
        chk("first_x", out_x, 0);
        chk("first_y", out_y, 0);
        run_walk(0);
        chk("t1_beats", beat_cnt - b0, 64);
        chk("t1_visible", vis_cnt - v0c, 36);
        chk("t1_last_count", last_cnt - l0, 1);
        chk("t1_done_count", done_cnt - d0c, 1);
        chk("t1_ua_11", cv_ua[1][1], 35);
        chk("t1_va_11", cv_va[1][1], 7);
        chk("t1_wa_11", cv_wa[1][1], 7);
        chk("t1_a_11", cv_a[1][1], 49);
        chk("t1_vis_11", cv_vis[1][1], 1);
        chk("t1_vis_77", cv_vis[7][7], 0);
        chk("t1_last_77", cv_last[7][7], 1);
        chk("t1_last_67", cv_last[6][7], 0);
        step();

        // clockwise winding
        snap();
        launch(0, 0, 0, 7, 7, 0);
        run_walk(0);
        chk("t2_beats", beat_cnt - b0, 64);
        chk("t2_visible", vis_cnt - v0c, 0);
        chk("t2_ua_00", cv_ua[0][0], 0);
        chk("t2_a_00", cv_a[0][0], 0);
        step();

        // backpressure at (2,0)
        snap();
        launch(0, 0, 7, 0, 0, 7);
        run_walk(2);
        chk("t3_hold_20", hold20 - h0, 4);
        chk("t3_beats", beat_cnt - b0, 64);
        chk("t3_visible", vis_cnt - v0c, 36);
        step();

        // start ignored mid-walk, then reset abort
        snap();
        launch(0, 0, 7, 0, 0, 7);
        run_walk(3);
        chk("t4_beats_before_abort", beat_cnt - b0, 29);
        repeat (3) step();
        chk("t4_no_done", done_cnt - d0c, 0);

`ifdef RASTER_BBOX_EN
        snap();
        launch(2, 2, 5, 2, 2, 5);
        run_walk(0);
        chk("t5_beats", beat_cnt - b0, 16);
        chk("t5_first_x", first_cx, 2);
        chk("t5_first_y", first_cy, 2);
        chk("t5_ua_33", cv_ua[3][3], 3);
        chk("t5_va_33", cv_va[3][3], 3);
        chk("t5_wa_33", cv_wa[3][3], 3);
        chk("t5_a_33", cv_a[3][3], 9);
        chk("t5_vis_33", cv_vis[3][3], 1);
        chk("t5_last_55", cv_last[5][5], 1);
        chk("t5_last_count", last_cnt - l0, 1);
        step();
`endif

        // random triangles, some large enough to saturate, with random backpressure
        for (int t = 0; t < 12; t++) begin
            int c[6];
            for (int k = 0; k < 6; k++)
                c[k] = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 1023) : $urandom_range(0, 9);
            if (t == 0) begin
                c[0] = 0; c[1] = 0; c[2] = 1023; c[3] = 0; c[4] = 0; c[5] = 1023;
            end
            snap();
            launch(c[0], c[1], c[2], c[3], c[4], c[5]);
            run_walk(1);
            chk("rnd_done_count", done_cnt - d0c, 1);
            if (t == 0) chk("rnd_sat_ua_00", cv_ua[0][0], 262143);
            repeat ($urandom_range(0, 2)) step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
